// File: rtl/jtag_pkg.sv
// Shared JTAG debug definitions: instruction register codes, byte width and
// the DR capture word for the host-to-target receive register.
`default_nettype none

package jtag_pkg;

  localparam int BYTE_W = 8;
  localparam int DR_W   = 32;

  typedef enum logic [2:0] {
    IR_CTRL = 3'd0,
    IR_ADDR = 3'd1,
    IR_DATA = 3'd2,
    IR_UART = 3'd3,
    IR_RXD  = 3'd4
  } ir_code_e;

  // The host polls bit 8 to throttle before its next DR update of IR_RXD.
  function automatic logic [DR_W-1:0] rxd_capture(input logic busy);
    return {23'b0, busy, 8'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_rx_fifo_if.sv
// Host write / CPU FWFT read bundle of the console receive FIFO.
`default_nettype none

interface jtag_rx_fifo_if
  import jtag_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
);

  logic [BYTE_W-1:0]   host_data;
  logic                host_we;
  logic                host_busy;
  logic [BYTE_W-1:0]   rx_data;
  logic                rx_valid;
  logic                rx_re;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;
  logic                overflow_clr;

  modport master (
    output host_data, host_we, rx_re, overflow_clr,
    input  host_busy, rx_data, rx_valid, count, overflow
  );

  modport slave (
    input  host_data, host_we, rx_re, overflow_clr,
    output host_busy, rx_data, rx_valid, count, overflow
  );

endinterface

`default_nettype wire

// File: rtl/jtag_fifo_ram.sv
// DEPTH x byte storage array: synchronous write, asynchronous read.
`default_nettype none

module jtag_fifo_ram
  import jtag_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [BYTE_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [BYTE_W-1:0]     rdata
);

  logic [BYTE_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/jtag_rx_fifo.sv
// Host-to-target console receive FIFO: single-strobe pushes from the JTAG side,
// first-word-fall-through pops from the CPU, sticky overflow on dropped bytes.
`default_nettype none

module jtag_rx_fifo
  import jtag_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input logic            clk,
  input logic            reset,
  jtag_rx_fifo_if.slave  bus
);

  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  overflow_q;
  logic [BYTE_W-1:0]     head;

  logic full;
  logic pop_ok;
  logic push_ok;
  logic drop;

  assign full    = (count_q == FULL_COUNT);
  assign pop_ok  = bus.rx_re && (count_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still takes the byte.
  assign push_ok = bus.host_we && (!full || pop_ok);
  assign drop    = bus.host_we && full && !pop_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + DEPTH_LOG2'(1);
      if (pop_ok)  rptr <= rptr + DEPTH_LOG2'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count_q <= count_q - (DEPTH_LOG2 + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop)                  overflow_q <= 1'b1;
      else if (bus.overflow_clr) overflow_q <= 1'b0;
    end
  end

  jtag_fifo_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok && !reset),
    .waddr (wptr),
    .wdata (bus.host_data),
    .raddr (rptr),
    .rdata (head)
  );

  // Stale array contents never leak out while the FIFO is empty.
  assign bus.rx_data   = (count_q != '0) ? head : '0;
  assign bus.rx_valid  = (count_q != '0);
  assign bus.host_busy = full;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;

endmodule

`default_nettype wire

// File: doc/jtag_rx_fifo.md
Name: jtag_rx_fifo

Overview:
- Host-to-target console input channel, the reverse of the loader's target-to-host UART path.
- The JTAG side writes bytes into this block one strobe at a time. The CPU drains them through a first-word-fall-through (FWFT) read interface.
- Sits in the clk domain, after the tck-to-clk toggle synchroniser. It accepts one single-cycle write pulse per host DR update and returns a full/busy flag that the JTAG capture path reports to the host.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO capacity in bytes (DEPTH = 2^DEPTH_LOG2 = 16 by default).

Ports:
- clk  in  1  system clock; everything is sampled on posedge.
- reset  in  1  synchronous, active-high reset.
- host_data  in  8  byte delivered by the JTAG side; valid only while host_we = 1.
- host_we  in  1  single-cycle push strobe, already synchronised into clk.
- host_busy  out  1  FIFO full; the JTAG side captures it so the host can throttle.
- rx_data  out  8  oldest byte (FWFT head); valid only while rx_valid = 1.
- rx_valid  out  1  FIFO non-empty.
- rx_re  in  1  pop strobe from the CPU.
- count  out  DEPTH_LOG2+1  number of bytes held, 0..DEPTH.
- overflow  out  1  sticky: a push was dropped.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Reset: while reset = 1, the next edge sets both pointers, count, rx_valid, rx_data, host_busy and overflow to 0. Reset overrides every other input in that cycle, including mid-burst pushes and pops. Stored contents are discarded.
- Storage: DEPTH-entry byte array with write and read pointers of DEPTH_LOG2 bits. Pointers wrap modulo DEPTH with no special case. count is a separate register and is the sole source of the full/empty decision.
- Push is accepted when host_we = 1 and either count < DEPTH, or count == DEPTH and a pop is accepted in the same cycle. An accepted push writes host_data at wptr and increments wptr.
- Pop is accepted when rx_re = 1 and count > 0. It increments rptr. rx_re with count == 0 is ignored, with no state change.
- count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- host_busy = (count == DEPTH). It is a combinational decode of the registered count.
- rx_valid = (count != 0).
- FWFT: rx_data always presents mem[rptr]. Read uses an asynchronous array read, or equivalent bypass logic; output is bit-exact either way.
- Push latency: a byte pushed into an empty FIFO is visible (rx_valid = 1, rx_data = byte) in the cycle after the host_we edge.
- Pop latency: after an accepted pop, the next byte (or rx_valid = 0) appears in the following cycle.
- Push and pop together with count == 1: the old head leaves, the new byte becomes head next cycle, and count stays 1.
- Dropped push: host_we = 1, count == DEPTH and no accepted pop. The byte is discarded, overflow is set to 1, and contents and pointers are unchanged.
- Overflow priority: overflow_clr clears overflow unless a dropped push occurs in the same cycle, in which case set wins.
- Ordering: strict FIFO. No byte is duplicated or reordered across pointer wrap.

Decomposition:
- Shared package jtag_pkg holds:
  - IR codes IR_CTRL = 0, IR_ADDR = 1, IR_DATA = 2, IR_UART = 3, IR_RXD = 4. IR_RXD is new; its DR capture is {23'b0, host_busy, 8'b0}, and its DR update drives host_we with dr[7:0].
  - Byte width constant BYTE_W = 8.
- One sub-module: jtag_fifo_ram, a parameterised DEPTH x 8 array with synchronous write and asynchronous read. Pointer, count and flag logic stays in jtag_rx_fifo.

Test Plan:
- Reset: assert reset 2 cycles with host_we = 1 and data 0xFF -> count = 0, rx_valid = 0, rx_data = 0x00, host_busy = 0, overflow = 0.
- Single byte: push 0x41 -> next cycle rx_valid = 1, rx_data = 0x41, count = 1. Pulse rx_re -> next cycle rx_valid = 0, count = 0. Extra rx_re while empty -> no change.
- Fill and overflow: push 0x00..0x0F -> host_busy = 1, count = 16. Push 0xAA -> dropped, overflow = 1, count = 16. Pop 16 times -> reads 0x00..0x0F in order, then rx_valid = 0.
- Full with simultaneous push/pop: fill with 0x10..0x1F, then one cycle with host_we = 1 (0x55) and rx_re = 1 -> overflow stays 0, count = 16. Draining yields 0x11..0x1F, 0x55.
- Overflow priority: when full, assert overflow_clr in the same cycle as a dropped push -> overflow = 1. Next cycle overflow_clr alone -> overflow = 0.
- Wrap and reset mid-operation: run 40 interleaved push/pop with random data versus a scoreboard -> no mismatch. With 5 bytes held, assert reset -> next cycle count = 0 and rx_valid = 0. A following push of 0x7E reads back as 0x7E.
